// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, field widths and helpers
package fetch_unit_pkg;

    localparam int XLEN     = 32;
    localparam int OP_W     = 6;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int TARGET_W = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        HOLD,
        WAIT_RES
    } fetch_state_t;

    // Field view the decoder uses: opcode on top, funct at the bottom.
    typedef struct packed {
        logic [OP_W-1:0]                op;
        logic [XLEN-OP_W-FUNCT_W-1:0]   body;
        logic [FUNCT_W-1:0]             funct;
    } instr_fields_t;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// rtl/fetch_unit_npc.sv - combinational next-PC selection (jump / branch / fall-through)
module fetch_unit_npc
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0]     pc,
    input  logic                jump,
    input  logic                taken,
    input  logic [IMM_W-1:0]    imm16,
    input  logic [TARGET_W-1:0] target26,
    output logic [XLEN-1:0]     next_pc
);

    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;

    // Jump wins over a taken branch; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], target26, 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + (sext_imm(imm16) << 2);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM: request, hold for decoder, wait for control-flow resolution
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [XLEN-1:0]     instr,
    output logic [XLEN-1:0]     pc,
    input  logic                res_valid,
    input  logic                res_jump,
    input  logic                res_taken,
    input  logic [IMM_W-1:0]    res_imm16,
    input  logic [TARGET_W-1:0] res_target26
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] next_pc;

    fetch_unit_npc npc (
        .pc       (pc),
        .jump     (res_jump),
        .taken    (res_taken),
        .imm16    (res_imm16),
        .target26 (res_target26),
        .next_pc  (next_pc)
    );

    // imem_req/imem_addr are set on entry to FETCH so they are registered
    // and already valid during the FETCH cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_reg      <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            pc          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_reg;
                end
                FETCH: begin
                    state <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    if (imem_ack) begin
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        pc          <= imem_addr;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state       <= WAIT_RES;
                        instr_valid <= 1'b0;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        state     <= FETCH;
                        pc_reg    <= next_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= next_pc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed fetch/branch/jump/reset vectors
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        res_valid = 1'b0;
    logic        res_jump = 1'b0;
    logic        res_taken = 1'b0;
    logic [15:0] res_imm16 = '0;
    logic [25:0] res_target26 = '0;

    int n_cmp = 0;
    int n_err = 0;
    int n_deliv = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_instr_q[$];

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .pc           (pc),
        .res_valid    (res_valid),
        .res_jump     (res_jump),
        .res_taken    (res_taken),
        .res_imm16    (res_imm16),
        .res_target26 (res_target26)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected addresses on each new request and expected
    // instructions on each decoder handshake; also checks hold stability.
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_valid = 1'b0;
        logic        prev_ready = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [31:0] prev_instr = '0;
        logic [31:0] prev_pc = '0;
        logic [31:0] ea;
        logic [63:0] ei;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                check("rst_imem_req", {31'b0, imem_req}, 32'd0);
                check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
                check("rst_instr", instr, 32'd0);
                check("rst_pc", pc, 32'd0);
                prev_req   = 1'b0;
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (imem_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL req_unexpected: got request to %h expected none", imem_addr);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("req_addr", imem_addr, ea);
                    end
                end
                if (imem_req && prev_req) begin
                    check("req_addr_stable", imem_addr, prev_addr);
                end
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", {31'b0, instr_valid}, 32'd1);
                    check("hold_instr", instr, prev_instr);
                    check("hold_pc", pc, prev_pc);
                end
                if (instr_valid && instr_ready) begin
                    n_deliv++;
                    if (exp_instr_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL instr_unexpected: got instr %h pc %h expected none", instr, pc);
                    end else begin
                        ei = exp_instr_q.pop_front();
                        check("instr", instr, ei[63:32]);
                        check("instr_pc", pc, ei[31:0]);
                    end
                end
                prev_req   = imem_req;
                prev_addr  = imem_addr;
                prev_valid = instr_valid;
                prev_ready = instr_ready;
                prev_instr = instr;
                prev_pc    = pc;
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_timeout: got imem_req=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic serve_mem(input int waits, input logic [31:0] data, input logic [31:0] at_pc);
        wait_req();
        @(negedge clk);
        repeat (waits) @(negedge clk);
        exp_instr_q.push_back({data, at_pc});
        imem_rdata = data;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    // Holds off the decoder, injects ignored ack/res noise, then resolves.
    task automatic serve_dec(input int rdelay, input logic early, input logic j, input logic t,
                             input logic [15:0] imm, input logic [25:0] tgt,
                             input logic [31:0] exp_next);
        if (rdelay > 0) begin
            imem_rdata = 32'hBAD0_BAD0;
            imem_ack   = 1'b1;
        end
        repeat (rdelay) begin
            @(negedge clk);
            imem_ack = 1'b0;
        end
        instr_ready = 1'b1;
        if (early) begin
            res_valid    = 1'b1;
            res_jump     = 1'b1;
            res_target26 = 26'h2AA_AAAA;
        end
        @(negedge clk);
        res_valid = 1'b0;
        res_jump  = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        exp_addr_q.push_back(exp_next);
        res_jump     = j;
        res_taken    = t;
        res_imm16    = imm;
        res_target26 = tgt;
        res_valid    = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_jump  = 1'b0;
        res_taken = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    initial begin
        #100000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        summary();
        $finish;
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_addr_q.push_back(32'h0000_3000);
        rst_n = 1'b1;

        // Release cycle is IDLE; FETCH next, WAIT_MEM, then HOLD.
        @(negedge clk);
        check("lat_req", {31'b0, imem_req}, 32'd1);
        check("lat_addr", imem_addr, 32'h0000_3000);
        @(negedge clk);
        check("lat_wait_valid", {31'b0, instr_valid}, 32'd0);
        exp_instr_q.push_back({32'h1111_1111, 32'h0000_3000});
        imem_rdata = 32'h1111_1111;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        check("lat_valid", {31'b0, instr_valid}, 32'd1);
        serve_dec(0, 1'b1, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_3004);

        serve_mem(3, 32'h2222_2222, 32'h0000_3004);
        serve_dec(5, 1'b0, 1'b0, 1'b1, 16'h0002, 26'h0, 32'h0000_3010);
        serve_mem(0, 32'h3333_3333, 32'h0000_3010);
        serve_dec(0, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'h0, 32'h0000_3004);
        serve_mem(1, 32'h4444_4444, 32'h0000_3004);
        serve_dec(0, 1'b1, 1'b0, 1'b1, 16'h0002, 26'h0, 32'h0000_3010);
        serve_mem(0, 32'h5555_5555, 32'h0000_3010);
        serve_dec(0, 1'b0, 1'b0, 1'b1, 16'h0003, 26'h0, 32'h0000_3020);
        serve_mem(2, 32'h6666_6666, 32'h0000_3020);
        serve_dec(1, 1'b0, 1'b0, 1'b1, 16'hFFF7, 26'h0, 32'h0000_3000);
        serve_mem(0, 32'h0800_0100, 32'h0000_3000);
        serve_dec(0, 1'b0, 1'b1, 1'b1, 16'h1234, 26'h000_0100, 32'h0000_0400);
        serve_mem(0, 32'h7777_7777, 32'h0000_0400);
        serve_dec(0, 1'b0, 1'b0, 1'b1, 16'h8000, 26'h0, 32'hFFFE_0404);
        serve_mem(0, 32'h8888_8888, 32'hFFFE_0404);
        serve_dec(0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 26'h0, 32'h0000_0404);
        serve_mem(0, 32'h9999_9999, 32'h0000_0404);
        serve_dec(0, 1'b0, 1'b0, 1'b1, 16'hFEFD, 26'h0, 32'hFFFF_FFFC);
        serve_mem(0, 32'hAAAA_AAAA, 32'hFFFF_FFFC);
        serve_dec(0, 1'b0, 1'b0, 1'b0, 16'h8000, 26'h3FF_FFFF, 32'h0000_0000);

        // Reset pulse in WAIT_MEM, with a stale ack right after release.
        wait_req();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_addr_q.push_back(32'h0000_3000);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rdata = 32'hDEAD_BEEF;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) begin
            check("abort_valid", {31'b0, instr_valid}, 32'd0);
            check("abort_req", {31'b0, imem_req}, 32'd1);
            @(negedge clk);
        end
        exp_instr_q.push_back({32'hBBBB_BBBB, 32'h0000_3000});
        imem_rdata = 32'hBBBB_BBBB;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        serve_dec(0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_3004);
        wait_req();
        repeat (3) @(negedge clk);

        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("instr_q_empty", 32'(exp_instr_q.size()), 32'd0);
        check("delivered", 32'(n_deliv), 32'd12);
        summary();
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, 32'h0000_3000, address of the first fetched instruction.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 The block SHALL have port imem_addr  output  32  word address of the request; bits [1:0] always 0.
REQ-006 The block SHALL have port imem_ack  input  1  memory completion strobe, one cycle, qualifies imem_rdata.
REQ-007 The block SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 The block SHALL have port instr_valid  output  1  instr/pc hold a fetched instruction for the decoder.
REQ-009 The block SHALL have port instr_ready  input  1  decoder accepts the instruction.
REQ-010 The block SHALL have port instr  output  32  instruction word; [31:26] opcode and [5:0] funct drive the decoder.
REQ-011 The block SHALL have port pc  output  32  address of instr.
REQ-012 The block SHALL have port res_valid  input  1  control-flow resolution for the last accepted instruction.
REQ-013 The block SHALL have port res_jump  input  1  instruction was J.
REQ-014 The block SHALL have port res_taken  input  1  conditional branch taken (BEQ/BNE condition met).
REQ-015 The block SHALL have port res_imm16  input  16  branch offset field.
REQ-016 The block SHALL have port res_target26  input  26  jump index field.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, WAIT_MEM, HOLD, WAIT_RES.
REQ-018 IDLE SHALL move to FETCH unconditionally on the next clock.
REQ-019 FETCH SHALL assert imem_req with imem_addr equal to the PC register for one cycle, then move to WAIT_MEM.
REQ-020 In WAIT_MEM, imem_req SHALL remain asserted with a stable address until the imem_ack cycle.
REQ-021 On imem_ack in WAIT_MEM, the block SHALL capture imem_rdata into instr, drop imem_req, and move to HOLD.
REQ-022 Minimum latency SHALL be 3 cycles from entering FETCH to instr_valid, for a zero-wait memory that acks in the first WAIT_MEM cycle.
REQ-023 In HOLD, instr_valid SHALL be 1 and instr/pc SHALL be stable until the cycle in which instr_ready=1.
REQ-024 On instr_valid && instr_ready, the FSM SHALL move to WAIT_RES, and instr_valid SHALL be 0 from the next cycle.
REQ-025 In WAIT_RES, the block SHALL wait for res_valid, then load the next PC and move to FETCH.
REQ-026 Next PC SHALL be {pc_plus4[31:28], res_target26, 2'b00} if res_jump=1.
REQ-027 Next PC SHALL be pc_plus4 + (sign_extend(res_imm16) << 2) if res_jump=0 and res_taken=1.
REQ-028 Next PC SHALL be pc_plus4 otherwise; res_jump takes priority over res_taken.
REQ-029 All PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 yields 0, and negative offsets wrap the same way.
REQ-030 imem_ack outside WAIT_MEM, and res_valid outside WAIT_RES, SHALL be ignored.
REQ-031 res_valid arriving in the same cycle that instr is accepted SHALL be ignored; resolution is taken only in WAIT_RES.
REQ-032 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in IDLE, the PC register SHALL equal RESET_PC, and imem_req, instr_valid, instr and pc SHALL all be 0.
REQ-034 Reset asserted in any state, including mid-WAIT_MEM, SHALL abort the operation immediately; a late imem_ack after release SHALL be ignored.
REQ-035 After release, the first request SHALL be to RESET_PC, issued two clocks later (IDLE, then FETCH).

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, RESET_PC default, and field widths (OP 6, FUNCT 6, IMM 16, TARGET 26), alongside the existing instruction and signal definitions.
REQ-037 Next-PC arithmetic SHALL live in one combinational sub-module, npc; the FSM and registers SHALL stay in fetch_unit.

Verification
REQ-038 Reset then zero-wait memory: imem_addr=32'h3000 on cycle 2 after release, instr_valid on cycle 4; with res_jump=0, res_taken=0, the next imem_addr is 32'h3004.
REQ-039 Memory acks after 3 wait cycles while instr_ready=0 for 5 cycles: imem_req is held with a stable address; instr/pc are stable until ready; exactly one instruction is delivered.
REQ-040 Branch at pc=32'h3010, res_taken=1, imm16=16'hFFFC: next imem_addr is 32'h3004; with imm16=16'h0003, next imem_addr is 32'h3020.
REQ-041 Jump at pc=32'h3000 with target26=26'h0000100 and res_taken=1: next imem_addr is 32'h0000_0400 (jump wins).
REQ-042 rst_n pulsed low during WAIT_MEM, ack delivered one cycle after release: ack is ignored, instr_valid stays 0, and the refetch goes to 32'h3000.
